// File: rtl/neuron_mac.sv
// neuron_mac: streaming signed int8 multiply-accumulate for one neuron.
// Accepts N_INPUTS (activation, weight) beats over a valid/ready handshake
// after a start pulse and presents the exact ACC_WIDTH-bit signed dot product
// until the consumer takes it.
// Optional feature macro: NEURON_MAC_BIAS_EN adds an int8 bias port whose
// sign-extended value seeds the accumulator on an accepted start.
module neuron_mac #(
  parameter int N_INPUTS  = 4,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_act,
  input  logic [7:0]           in_weight,
`ifdef NEURON_MAC_BIAS_EN
  input  logic [7:0]           bias,
`endif
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 busy
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;

  logic                        w_start_acc;
  logic                        w_beat;
  logic                        w_last_beat;
  logic signed [15:0]          w_prod;
  logic signed [ACC_WIDTH-1:0] w_acc_init;

  // Full-precision int8 x int8 product widened to the accumulator width.
  // A legal ACC_WIDTH is always wider than 16, so this is a pure sign
  // extension; an undersized accumulator simply truncates (wraps).
  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [15:0] p
  );
    return ACC_WIDTH'(p);
  endfunction

  // Bias enters the sum unscaled: sign-extend only, no shift.
  function automatic logic signed [ACC_WIDTH-1:0] sext_bias(
    input logic signed [7:0] b
  );
    return ACC_WIDTH'(b);
  endfunction

  // Both operands are signed 8-bit, so -128 x -128 = +16384 fits in 16 bits.
  assign w_prod = $signed(in_act) * $signed(in_weight);

`ifdef NEURON_MAC_BIAS_EN
  assign w_acc_init = sext_bias($signed(bias));
`else
  assign w_acc_init = '0;
`endif

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_beat      = in_valid && in_ready;
  assign w_last_beat = (r_cnt == LAST_BEAT);
  assign sum         = r_acc;

  // Next-state decode and handshake outputs; start and in_valid are only
  // looked at in the state that honours them.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    sum_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last_beat) w_state_nxt = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (sum_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Beat counter: cleared on start, advances only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
    end
  end

  // Accumulator: seeded on start, adds one product per accepted beat and
  // then holds the finished sum through DONE. Reset clears it so no partial
  // sum survives an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_start_acc) begin
      r_acc <= w_acc_init;
    end else if (w_beat) begin
      r_acc <= r_acc + sext_prod(w_prod);
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Testbench for neuron_mac: table vectors, multi-cycle corner sequences and
// randomized operations against a plain-arithmetic dot-product model.
module tb_neuron_mac;

  localparam int N  = 4;
  localparam int AW = 20;
`ifdef NEURON_MAC_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          sum_ready = 1'b0;
  logic [7:0]    in_act    = '0;
  logic [7:0]    in_weight = '0;
`ifdef NEURON_MAC_BIAS_EN
  logic [7:0]    bias_drv  = '0;
`endif
  logic          in_ready;
  logic          sum_valid;
  logic          busy;
  logic [AW-1:0] sum;

  neuron_mac #(.N_INPUTS(N), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_weight (in_weight),
`ifdef NEURON_MAC_BIAS_EN
    .bias      (bias_drv),
`endif
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int op_act[N];
  int op_wgt[N];
  int op_bias;
  int op_gap;

  typedef struct packed {
    logic [31:0]        acts;   // beat 0 in bits [7:0]
    logic [31:0]        wgts;
    logic signed [7:0]  b;
    logic [3:0]         gap;
    logic signed [31:0] exp;    // expected sum without bias
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: bias plus the exact sum of products, reduced to AW bits.
  function automatic logic signed [63:0] ref_sum();
    longint s;
    logic signed [AW-1:0] wrapped;
    s = BIAS_EN ? longint'(op_bias) : 0;
    for (int i = 0; i < N; i++) s += longint'(op_act[i]) * longint'(op_wgt[i]);
    wrapped = AW'(s);
    return wrapped;
  endfunction

  task automatic drive_bias(input int b);
`ifdef NEURON_MAC_BIAS_EN
    bias_drv = 8'(b);
`else
    if (b != 0) in_act = in_act;
`endif
  endtask

  // Starts one operation from IDLE (called at posedge+1) and feeds op_* beats.
  task automatic run_op(input string tag, input logic signed [63:0] exp_sum,
                        input bit do_hs);
    start    = 1'b1;
    in_valid = 1'b0;
    drive_bias(op_bias);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " in_ready_after_start"}, in_ready, 1);
    chk({tag, " busy_after_start"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        for (int g = 0; g < op_gap; g++) begin
          in_valid  = 1'b0;
          in_act    = 8'($urandom);
          in_weight = 8'($urandom);
          @(posedge clk); #1;
          chk({tag, " sum_valid_in_gap"}, sum_valid, 0);
        end
      end
      in_valid  = 1'b1;
      in_act    = 8'(op_act[i]);
      in_weight = 8'(op_wgt[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < N - 1) begin
        chk({tag, " in_ready_mid"}, in_ready, 1);
        chk({tag, " sum_valid_mid"}, sum_valid, 0);
      end else begin
        chk({tag, " sum_valid_after_last"}, sum_valid, 1);
        chk({tag, " in_ready_after_last"}, in_ready, 0);
      end
    end
    chk({tag, " sum"}, $signed(sum), exp_sum);
    if (do_hs) begin
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
      chk({tag, " sum_valid_after_hs"}, sum_valid, 0);
      chk({tag, " busy_after_hs"}, busy, 0);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      op_act[i] = int'($signed(v.acts[i*8 +: 8]));
      op_wgt[i] = int'($signed(v.wgts[i*8 +: 8]));
    end
    op_bias = int'(v.b);
    op_gap  = int'(v.gap);
  endtask

  task automatic set_ones(input int b);
    for (int i = 0; i < N; i++) begin
      op_act[i] = 1;
      op_wgt[i] = 1;
    end
    op_bias = b;
    op_gap  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [63:0] e;

    tbl[0] = '{acts: {8'd4, 8'd3, 8'd2, 8'd1}, wgts: {8'd1, 8'd1, 8'd1, 8'd1},
               b: 8'sd0, gap: 4'd0, exp: 32'sd10};
    tbl[1] = '{acts: {8'h80, 8'h80, 8'h80, 8'h80}, wgts: {8'h80, 8'h80, 8'h80, 8'h80},
               b: 8'sd0, gap: 4'd0, exp: 32'sd65536};
    tbl[2] = '{acts: {8'h7F, 8'h7F, 8'h7F, 8'h7F}, wgts: {8'h80, 8'h80, 8'h80, 8'h80},
               b: 8'sd0, gap: 4'd0, exp: -32'sd65024};
    tbl[3] = '{acts: {8'd0, 8'd7, 8'hFD, 8'd5}, wgts: {8'd9, 8'hFF, 8'd4, 8'd2},
               b: 8'sd0, gap: 4'd2, exp: -32'sd9};
    tbl[4] = '{acts: {8'd2, 8'd2, 8'd2, 8'd2}, wgts: {8'd3, 8'd3, 8'd3, 8'd3},
               b: -8'sd5, gap: 4'd0, exp: 32'sd24};
    tbl[5] = '{acts: {8'h80, 8'h7F, 8'h80, 8'h7F}, wgts: {8'h80, 8'h80, 8'h7F, 8'h7F},
               b: 8'sd100, gap: 4'd1, exp: 32'sd1};

    // Reset state while rst_n is held low.
    #3;
    chk("reset sum", $signed(sum), 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset sum_valid", sum_valid, 0);
    chk("reset busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sum_ready while idle does nothing.
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    chk("idle sum_ready sum_valid", sum_valid, 0);
    chk("idle sum_ready busy", busy, 0);

    // Table vectors.
    for (int k = 0; k < 6; k++) begin
      load_vec(tbl[k]);
      e = tbl[k].exp + (BIAS_EN ? op_bias : 0);
      run_op($sformatf("vec%0d", k), e, 1'b1);
    end

    // Hold the result with sum_ready low while start/in_valid are pushed.
    load_vec(tbl[0]);
    op_bias = 7;
    e = 10 + (BIAS_EN ? 7 : 0);
    run_op("hold", e, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start     = 1'b1;
      in_valid  = 1'b1;
      in_act    = 8'($urandom);
      in_weight = 8'($urandom);
      @(posedge clk); #1;
      chk("hold sum", $signed(sum), e);
      chk("hold sum_valid", sum_valid, 1);
      chk("hold in_ready", in_ready, 0);
      chk("hold busy", busy, 1);
    end
    in_valid  = 1'b0;
    drive_bias(0);
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    chk("hs_cycle start ignored in_ready", in_ready, 0);
    chk("hs_cycle sum_valid", sum_valid, 0);
    chk("hs_cycle busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start after hs in_ready", in_ready, 1);
    chk("start after hs busy", busy, 1);
    for (int i = 0; i < N; i++) begin
      in_valid  = 1'b1;
      in_act    = 8'd1;
      in_weight = 8'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("post_hold sum_valid", sum_valid, 1);
    chk("post_hold sum", $signed(sum), 4);
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    chk("post_hold idle", busy, 0);

    // Asynchronous reset in the middle of accumulation.
    drive_bias(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_act    = 8'd9;
      in_weight = 8'd9;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset sum", $signed(sum), 0);
    chk("midreset in_ready", in_ready, 0);
    chk("midreset sum_valid", sum_valid, 0);
    chk("midreset busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_ones(0);
    run_op("after_reset", 64'sd4, 1'b1);

    // Randomized operations against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        op_act[i] = int'($urandom_range(0, 255)) - 128;
        op_wgt[i] = int'($urandom_range(0, 255)) - 128;
      end
      op_bias = int'($urandom_range(0, 255)) - 128;
      op_gap  = int'($urandom_range(0, 2));
      run_op($sformatf("rand%0d", r), ref_sum(), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
